// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction field bundles into 32-bit H2BP words and streams them to instruction memory
module instr_encoder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] word_count
);

  localparam logic [4:0] OP_LW = 5'h08;
  localparam logic [4:0] OP_SB = 5'h0B;
  localparam logic [4:0] OP_J  = 5'h0C;
  localparam logic [4:0] OP_JR = 5'h0D;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              last_pending;
  logic [31:0]       enc_word;
  logic              bad_op, bad_rng, legal;
  logic [1:0]        code;
  logic              fit12, fit16, fit22, fit27, is_mem_op;
  logic              accept, wr_fire;

  // A value fits an n-bit signed field when every bit above n-1 copies the sign bit.
  assign fit12     = (in_imm[31:11] == {21{in_imm[11]}});
  assign fit16     = (in_imm[31:15] == {17{in_imm[15]}});
  assign fit22     = (in_imm[31:21] == {11{in_imm[21]}});
  assign fit27     = (in_imm[31:26] == {6{in_imm[26]}});
  assign is_mem_op = (in_op >= OP_LW) && (in_op <= OP_SB);

  always_comb begin
    enc_word = '0;
    bad_op   = 1'b0;
    bad_rng  = 1'b0;
    case (in_fmt)
      3'd0: begin
        enc_word = {1'b0, in_op[2:0], 1'b0, in_rd, in_rs1, in_rs2, in_imm[11:0]};
        bad_rng  = !fit12;
      end
      3'd1, 3'd2: begin
        enc_word = {1'b0, in_op[2:0], 1'b1, in_rd, in_rs1, in_imm[15:0], in_fmt[1]};
        bad_rng  = !fit16;
      end
      3'd3: begin
        enc_word = {in_op, in_rd, in_rs1, in_imm[15:0], 1'b0};
        bad_op   = !is_mem_op;
        bad_rng  = !fit16;
      end
      3'd4: begin
        enc_word = {in_op, in_imm[26:0]};
        bad_op   = (in_op != OP_J);
        bad_rng  = !fit27;
      end
      3'd5: begin
        enc_word = {in_op, in_rs1, in_imm[21:0]};
        bad_op   = (in_op != OP_JR);
        bad_rng  = !fit22;
      end
      3'd6: begin
        enc_word = {in_op, in_rd, in_rs1, in_imm[15:0], 1'b0};
        bad_op   = !in_op[4] || (in_op[2:0] == 3'b111) || is_mem_op ||
                   (in_op == OP_J) || (in_op == OP_JR);
        bad_rng  = !fit16;
      end
      default: bad_op = 1'b1;
    endcase
  end

  assign legal    = !(bad_op || bad_rng);
  assign code     = bad_op ? 2'd2 : (bad_rng ? 2'd1 : 2'd0);
  assign in_ready = (state == S_RUN) && (!mem_we || mem_ready) && !last_pending;
  assign accept   = in_valid && in_ready;
  assign wr_fire  = mem_we && mem_ready;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (accept && !legal)           state_nxt = S_ERR;
        else if (wr_fire && last_pending) state_nxt = S_IDLE;
      end
      S_ERR: if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ptr          <= '0;
      word_count   <= '0;
      last_pending <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_RUN) && wr_fire && last_pending;
      if (start && (state != S_RUN)) begin
        ptr          <= base_addr;
        word_count   <= '0;
        err          <= 1'b0;
        err_code     <= 2'd0;
        mem_we       <= 1'b0;
        last_pending <= 1'b0;
      end else begin
        if (wr_fire) begin
          ptr        <= ptr + 1'b1;
          word_count <= word_count + 1'b1;
        end
        // The new word goes to the slot after the one being retired this cycle.
        if (accept && legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_fire ? ptr + 1'b1 : ptr;
          mem_wdata <= enc_word;
        end else if (wr_fire) begin
          mem_we <= 1'b0;
        end
        if (accept && legal && in_last) last_pending <= 1'b1;
        else if (wr_fire)               last_pending <= 1'b0;
        if (accept && !legal) begin
          err      <= 1'b1;
          err_code <= code;
        end
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Accepts one field bundle per handshake (format, opcode, register addresses, immediate). Packs it into a 32-bit H2BP instruction word and writes it to instruction memory at consecutive word addresses.
- Used by the boot/debug loader to build programs in hardware.
- Validates field ranges and halts on the first illegal bundle.

Parameters:
ADDR_W, 16, instruction-memory word-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; loads base_addr, clears counters/errors, enters RUN
base_addr  in  ADDR_W  first write address
in_valid  in  1  field bundle valid
in_ready  out  1  encoder accepts bundle this cycle
in_fmt  in  3  0 R3, 1 R2 imm-offset, 2 R2 imm-as-reg, 3 MEM, 4 J, 5 JR, 6 BR, 7 reserved
in_op  in  5  fmt0-2: op[2:0] = ALU/FPU operation; fmt3-6: major opcode [31:27]
in_rd, in_rs1, in_rs2  in  5 each  register addresses
in_imm  in  32  signed immediate
in_last  in  1  bundle is the final instruction
mem_we  out  1  write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  encoded word
mem_ready  in  1  memory accepts write when mem_we & mem_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last write is accepted
err  out  1  sticky illegal-bundle flag
err_code  out  2  1 imm out of range, 2 bad opcode/format, 0 none
word_count  out  ADDR_W  words written since start

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE. mem_we, done, err, in_ready = 0. err_code, word_count, mem_addr, mem_wdata = 0.
- States:
  - IDLE: start -> RUN, address pointer = base_addr.
  - RUN: the last bundle's write is accepted -> IDLE with done = 1 for one cycle.
  - RUN: an illegal bundle is accepted -> ERR.
  - ERR: in_ready = 0; only start or rst leave ERR. start -> RUN, clears err/err_code.
- start while RUN is ignored.
- Pipeline and handshake:
  - One output register stage.
  - in_ready = (state==RUN) & (!mem_we | mem_ready) & !last_pending.
  - A bundle is accepted on in_valid & in_ready. The encoded word appears on mem_wdata, with mem_we = 1, on the next cycle. Latency is 1.
  - mem_we, mem_addr and mem_wdata hold stable while mem_ready = 0.
  - When a write is accepted: pointer +1 (wraps at 2^ADDR_W), word_count +1.
  - Back-to-back throughput is 1 word/cycle when mem_ready = 1.
  - last_pending is set when a last bundle is accepted and cleared when its write is accepted.
- Encoding (all unlisted bits 0):
  - fmt0: [31]=0, [30:28]=op[2:0], [27]=0, [26:22]=rd, [21:17]=rs1, [16:12]=rs2, [11:0]=imm[11:0]. imm must be in -2048..2047.
  - fmt1/2: [31]=0, [30:28]=op[2:0], [27]=1, [26:22]=rd, [21:17]=rs1, [16:1]=imm[15:0], [0]=0 (fmt1) or 1 (fmt2). imm must be in -32768..32767.
  - fmt3: [31:27]=op, which must be in [LW:SB]. [26:22]=rd, [21:17]=rs1, [16:1]=imm16, [0]=0.
  - fmt4: [31:27]=op, which must equal J. [26:0]=imm[26:0]. imm must be a 27-bit signed value.
  - fmt5: [31:27]=op, which must equal JR. [26:22]=rs1, [21:0]=imm[21:0]. imm must be a 22-bit signed value.
  - fmt6: [31:27]=op. op[4] must be 1 and op[2:0] != 3'b111. op must not be in [LW:SB], J or JR. [26:22]=rd, [21:17]=rs1, [16:1]=imm16.
- Error rules:
  - fmt7 or an opcode violation -> err_code 2.
  - Range violation only -> err_code 1.
  - If both apply, code 2 wins.
  - An illegal bundle is consumed but never written; word_count is not advanced.
  - A previously accepted legal word still completes its write.
- rst mid-write drops the pending write immediately.

Test Plan:
- start base_addr=0x0100; fmt0 op=2 rd=3 rs1=1 rs2=2 imm=-1 -> mem_addr 0x0100, mem_wdata 0x20C22FFF one cycle after accept.
- fmt2 op=1 rd=5 rs1=5 imm=100 -> mem_wdata 0x194A00C9. fmt4 op=J imm=-4 -> {J,27'h7FFFFFC}.
- Three legal bundles, third with in_last, mem_ready=1 -> addresses 0x100/0x101/0x102, done pulse 1 cycle after third write, word_count=3, busy=0.
- mem_ready low 3 cycles during a write -> mem_we/addr/wdata stable, in_ready=0, no word lost or duplicated.
- fmt0 imm=2048 -> no write, err=1, err_code=1, state ERR, in_ready=0. start -> err cleared, word_count=0.
- fmt6 op with op[2:0]=3'b111, and separately fmt7 -> err_code=2. rst during a stalled write -> mem_we=0 the next cycle.
